btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Front-end stage for the operand/opcode loader.
- Takes the three raw push-buttons (A, B, Op) and synchronizes each to clk, then debounces it.
- Emits one single-cycle, mutually exclusive load strobe per accepted press, so a physical press loads a register exactly once.
- Its outputs drive the loader's btn_A/btn_B/btn_Op inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); legal range ≥ 2.
- REPEAT_CYCLES, 50000000, auto-repeat period in cycles while a button is held; used only with the optional feature; legal range ≥ 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_A_raw  in  1  raw asynchronous button for operand A
- btn_B_raw  in  1  raw asynchronous button for operand B
- btn_Op_raw  in  1  raw asynchronous button for the opcode
- btn_A  out  1  one-cycle load strobe for A
- btn_B  out  1  one-cycle load strobe for B
- btn_Op  out  1  one-cycle load strobe for Op
- collision  out  1  one-cycle flag: two or more strobes coincided and were all suppressed

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset: all synchronizer FFs, debounced levels, counters and outputs go to 0, and are held at 0 while reset=1.
- Per channel, a 2-FF synchronizer gives s. The debounced level is d; the counter is cnt.
  - s==d: cnt<=0.
  - s!=d and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - s!=d and cnt==DEBOUNCE_CYCLES-1: d<=s, cnt<=0.
  - cnt width is $clog2(DEBOUNCE_CYCLES).
- Raw press pulse p is registered and asserted the same edge d goes 0→1. Release (d 1→0) produces nothing.
- Latency: raw high first sampled at edge k and held → p high for exactly the cycle after edge k+DEBOUNCE_CYCLES+1.
- Bounce: any s toggle back to d before the count completes clears cnt. Glitches shorter than DEBOUNCE_CYCLES never produce a strobe.
- Exclusion stage is combinational from the registered p's:
  - Exactly one p high: the matching output is high and collision=0.
  - Two or three p high: all three outputs are 0 and collision=1 for that cycle. The presses are consumed and are not retried.
- A held button gives exactly one strobe, no matter how long it is held (base build).
- Button held through reset deassertion: d restarts at 0, so one strobe fires DEBOUNCE_CYCLES+2 cycles after reset falls. This is intended.
- Reset asserted mid-count: the count is abandoned and no strobe is emitted.
- Output invariant: at most one of btn_A/btn_B/btn_Op is high in any cycle.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter rcnt of width $clog2(REPEAT_CYCLES).
  - rcnt is cleared when d==0 and counts while d==1.
  - At rcnt==REPEAT_CYCLES-1, p pulses again and rcnt wraps to 0.
  - First repeat occurs REPEAT_CYCLES cycles after the initial strobe. Repeats pass through the exclusion stage.
- Undefined: no repeat logic, REPEAT_CYCLES is ignored, and there is one strobe per press.

Decomposition:
- Package btn_pkg holds:
  - channel index constants BTN_IDX_A=2, BTN_IDX_B=1, BTN_IDX_OP=0 (matching the {btn_A,btn_B,btn_Op} concatenation order);
  - N_BTN=3;
  - DEBOUNCE_CYCLES and REPEAT_CYCLES default constants.
- Sub-module btn_debounce (synchronizer + debounce counter + press pulse + optional repeat) is instantiated three times.
- Exclusion logic stays in btn_conditioner.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4: btn_A_raw rises before edge 0 and holds 20 cycles → btn_A high only in cycle after edge 5; btn_B=btn_Op=collision=0 throughout.
- Bounce, DEBOUNCE_CYCLES=4: btn_B_raw pattern 1,1,0,1,1,0,1 then steady 1 → no strobe during bounce; single btn_B strobe DEBOUNCE_CYCLES+1 edges after the final steady rise is sampled.
- Collision: btn_A_raw and btn_Op_raw rise sampled at the same edge → in the strobe cycle all outputs 0 and collision=1; no later strobes while held.
- Reset mid-debounce: btn_Op_raw rises, reset=1 for 1 cycle at edge 3 with raw still high → no strobe before reset; one btn_Op strobe DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Release and re-press: hold btn_A_raw 10 cycles, release 10 cycles, press again → exactly two btn_A strobes, none on release.
- BTN_AUTOREPEAT_EN, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8: hold btn_B_raw 40 cycles → strobes at cycles t0, t0+8, t0+16, t0+24, …; they stop within DEBOUNCE_CYCLES+2 cycles of release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button front end (btn_conditioner).
package btn_pkg;

  localparam int N_BTN      = 3;
  localparam int BTN_IDX_A  = 2;
  localparam int BTN_IDX_B  = 1;
  localparam int BTN_IDX_OP = 0;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int REPEAT_CYCLES_DEF   = 50000000;

  typedef logic [N_BTN-1:0] btn_vec_t;

  // True when two or more bits of v are set.
  function automatic logic multi_hot(input btn_vec_t v);
    return (v & (v - btn_vec_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer, stability counter, registered press pulse.
// Optional auto-repeat while held when BTN_AUTOREPEAT_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic p_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_deb_chk
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_rep_chk
    $error("btn_debounce: REPEAT_CYCLES must be >= 2");
  end

  logic          s1_q, s2_q;
  logic          d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p_q, p_d;
  logic          rise;

  always_comb begin
    d_d   = d_q;
    cnt_d = cnt_q;
    if (s2_q == d_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      d_d   = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Only the 0->1 transition of the debounced level is a press.
  assign rise = ~d_q & d_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RCNT_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rep;

  always_comb begin
    rep    = 1'b0;
    rcnt_d = '0;
    if (d_q) begin
      if (rcnt_q == RCNT_MAX) begin
        rep = 1'b1;
      end else begin
        rcnt_d = rcnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end

  assign p_d = rise | rep;
`else
  assign p_d = rise;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      d_q   <= 1'b0;
      cnt_q <= '0;
      p_q   <= 1'b0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      d_q   <= d_d;
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/btn_conditioner.sv
// Three debounced button channels feeding a mutually exclusive load-strobe stage.
// Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_A_raw,
  input  logic btn_B_raw,
  input  logic btn_Op_raw,
  output logic btn_A,
  output logic btn_B,
  output logic btn_Op,
  output logic collision
);

  btn_vec_t raw;
  btn_vec_t p;
  btn_vec_t strobe_d;
  logic     collision_d;

  assign raw = {btn_A_raw, btn_B_raw, btn_Op_raw};

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw_i(raw[i]),
      .p_o  (p[i])
    );
  end

  // Coinciding presses are dropped entirely rather than arbitrated.
  always_comb begin
    collision_d = multi_hot(p);
    strobe_d    = collision_d ? '0 : p;
  end

  assign btn_A     = strobe_d[BTN_IDX_A];
  assign btn_B     = strobe_d[BTN_IDX_B];
  assign btn_Op    = strobe_d[BTN_IDX_OP];
  assign collision = collision_d;

endmodule

// File: tb/tb_btn_conditioner.sv
// Table-driven bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_btn_conditioner;

  localparam int D = 4;
  localparam int R = 8;

  logic clk = 1'b0;
  logic reset;
  logic a_raw, b_raw, op_raw;
  logic btn_A, btn_B, btn_Op, collision;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_A_raw (a_raw),
    .btn_B_raw (b_raw),
    .btn_Op_raw(op_raw),
    .btn_A     (btn_A),
    .btn_B     (btn_B),
    .btn_Op    (btn_Op),
    .collision (collision)
  );

  // want = {btn_A, btn_B, btn_Op, collision} just after the edge that samples rst/raw.
  typedef struct {
    logic       rst;
    logic [2:0] raw;
    logic [3:0] want;
    logic       chk;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb_want[$];
  logic       sb_chk[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic add(input logic rst, input logic [2:0] raw, input int n, input logic chk = 1'b1);
    vec_t v;
    v.rst  = rst;
    v.raw  = raw;
    v.want = 4'b0000;
    v.chk  = chk;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic mark(input int idx, input logic [3:0] want);
    vecs[idx].want = want;
  endtask

  initial begin
    int         b;
    logic [3:0] act;
    logic [3:0] want;
    logic       chk;

    reset  = 1'b1;
    a_raw  = 1'b0;
    b_raw  = 1'b0;
    op_raw = 1'b0;

    // Reset held with all buttons pressed: everything stays quiet.
    add(1'b1, 3'b111, 4);

`ifndef BTN_AUTOREPEAT_EN
    // Clean press of A, held 20 cycles, then released.
    add(1'b1, 3'b000, 2);
    b = vecs.size();
    add(1'b0, 3'b100, 20);
    add(1'b0, 3'b000, 8);
    mark(b + 5, 4'b1000);

    // Bounce on B: 1,1,0,1,1,0,1 then steady high from index 6.
    add(1'b1, 3'b000, 2);
    b = vecs.size();
    add(1'b0, 3'b010, 2);
    add(1'b0, 3'b000, 1);
    add(1'b0, 3'b010, 2);
    add(1'b0, 3'b000, 1);
    add(1'b0, 3'b010, 14);
    mark(b + 11, 4'b0100);

    // A and Op rise together: one collision cycle, no strobes.
    add(1'b1, 3'b000, 2);
    b = vecs.size();
    add(1'b0, 3'b101, 20);
    mark(b + 5, 4'b0001);

    // Op held, reset pulsed at index 3: strobe DEBOUNCE_CYCLES+2 after reset falls.
    add(1'b1, 3'b000, 2);
    b = vecs.size();
    add(1'b0, 3'b001, 3);
    add(1'b1, 3'b001, 1);
    add(1'b0, 3'b001, 16);
    mark(b + 9, 4'b0010);

    // A pressed, released, pressed again: two strobes, none on release.
    add(1'b1, 3'b000, 2);
    b = vecs.size();
    add(1'b0, 3'b100, 10);
    add(1'b0, 3'b000, 10);
    add(1'b0, 3'b100, 20);
    mark(b + 5,  4'b1000);
    mark(b + 25, 4'b1000);
`else
    // B held 40 cycles: first strobe then one every REPEAT_CYCLES.
    add(1'b1, 3'b000, 2);
    b = vecs.size();
    add(1'b0, 3'b010, 40);
    add(1'b0, 3'b000, 2);
    add(1'b0, 3'b000, D + 2, 1'b0);
    add(1'b0, 3'b000, 8);
    for (int k = 0; k < 5; k++) mark(b + 5 + k * R, 4'b0100);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      {a_raw, b_raw, op_raw} = vecs[i].raw;
      sb_want.push_back(vecs[i].want);
      sb_chk.push_back(vecs[i].chk);
      @(posedge clk);
      #1;
      act  = {btn_A, btn_B, btn_Op, collision};
      want = sb_want.pop_front();
      chk  = sb_chk.pop_front();
      if (chk) begin
        n_cmp++;
        if (act !== want) begin
          n_err++;
          $display("FAIL vec%0d outputs {A,B,Op,col}: got %b expected %b", i, act, want);
        end
      end
      n_cmp++;
      if ($countones({btn_A, btn_B, btn_Op}) > 1) begin
        n_err++;
        $display("FAIL vec%0d exclusive: got %b expected at most one strobe", i,
                 {btn_A, btn_B, btn_Op});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
